// File: rtl/sprite_blitter.sv
// Sprite ROM reader: streams a SPRITE_W x SPRITE_H tile out of the ROM and writes it
// into the framebuffer at (cmd_x, cmd_y), with edge clipping and optional transparency.
module sprite_blitter #(
  parameter int         SPRITE_W         = 30,
  parameter int         SPRITE_H         = 30,
  parameter int         FB_W             = 160,
  parameter int         FB_H             = 120,
  parameter int         FB_AW            = 15,
  parameter logic [7:0] TRANSPARENT      = 8'hFF,
  parameter bit         SKIP_TRANSPARENT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd_color,
  input  logic [2:0]       cmd_number,
  input  logic [7:0]       cmd_x,
  input  logic [6:0]       cmd_y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       rom_color,
  output logic [2:0]       rom_number,
  output logic [9:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_data
);
  localparam int         CW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int         RW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [9:0] LAST  = 10'(SPRITE_W * SPRITE_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(SPRITE_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        r_state;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [1:0]    r_color;
  logic [2:0]    r_number;
  logic [9:0]    r_addr;
  logic [CW-1:0] r_col, r_col_d;
  logic [RW-1:0] r_row, r_row_d;
  logic          r_vld;
  logic          r_busy, r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_color  <= '0;
      r_number <= '0;
      r_addr   <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_col_d  <= '0;
      r_row_d  <= '0;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // row/col/valid trail the address by one cycle to line up with rom_data
      r_vld   <= (r_state == FETCH);
      r_col_d <= r_col;
      r_row_d <= r_row;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_x      <= cmd_x;
          r_y      <= cmd_y;
          r_color  <= cmd_color;
          r_number <= cmd_number;
          r_addr   <= '0;
          r_col    <= '0;
          r_row    <= '0;
          r_busy   <= 1'b1;
          r_state  <= FETCH;
        end
        FETCH: begin
          if (r_addr == LAST) begin
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + 10'd1;
            if (r_col == COL_MAX) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Full-width screen coordinates so off-screen pixels never alias back on screen
  logic [15:0]      w_fx, w_fy;
  logic             w_inb, w_transp, w_we;
  logic [FB_AW-1:0] w_addr;

  assign w_fx     = 16'(r_x) + 16'(r_col_d);
  assign w_fy     = 16'(r_y) + 16'(r_row_d);
  assign w_inb    = (32'(w_fx) < FB_W) && (32'(w_fy) < FB_H);
  assign w_transp = SKIP_TRANSPARENT && (rom_data == TRANSPARENT);
  assign w_we     = r_vld && w_inb && !w_transp;
  assign w_addr   = FB_AW'(32'(w_fy) * FB_W + 32'(w_fx));

  assign busy       = r_busy;
  assign done       = r_done;
  assign rom_color  = r_color;
  assign rom_number = r_number;
  assign rom_addr   = r_addr;
  assign fb_we      = w_we;
  assign fb_addr    = w_we ? w_addr : '0;
  assign fb_data    = w_we ? rom_data : 8'h00;
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (transparency skipped / kept) share one command
// stream and are compared every cycle against a cycle-offset model of a blit.
module tb_sprite_blitter;
  localparam int W = 30, H = 30, FBW = 160, FBH = 120;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0;
  logic [1:0]  cmd_color = '0;
  logic [2:0]  cmd_number = '0;
  logic [7:0]  cmd_x = '0;
  logic [6:0]  cmd_y = '0;

  logic        busy [2], done [2], fb_we [2];
  logic [1:0]  rom_color [2];
  logic [2:0]  rom_number [2];
  logic [9:0]  rom_addr [2];
  logic [7:0]  rom_data [2];
  logic [14:0] fb_addr [2];
  logic [7:0]  fb_data [2];

  always #5 clk = ~clk;

  // index 0 skips transparent pixels, index 1 writes them
  sprite_blitter #(.SKIP_TRANSPARENT(1'b1)) u_skip (
    .clk(clk), .reset(reset), .start(start), .cmd_color(cmd_color), .cmd_number(cmd_number),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .busy(busy[0]), .done(done[0]), .rom_color(rom_color[0]),
    .rom_number(rom_number[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .fb_we(fb_we[0]), .fb_addr(fb_addr[0]), .fb_data(fb_data[0]));
  sprite_blitter #(.SKIP_TRANSPARENT(1'b0)) u_keep (
    .clk(clk), .reset(reset), .start(start), .cmd_color(cmd_color), .cmd_number(cmd_number),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .busy(busy[1]), .done(done[1]), .rom_color(rom_color[1]),
    .rom_number(rom_number[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .fb_we(fb_we[1]), .fb_addr(fb_addr[1]), .fb_data(fb_data[1]));

  function automatic logic [7:0] rom_f(input logic [1:0] c, input logic [2:0] nm, input int k);
    logic [7:0] kb;
    kb = k[7:0];
    if (nm >= 3'd4) return 8'hFF;
    return kb ^ 8'h5A ^ {1'b0, nm, 2'b00, c};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) rom_data[i] <= rom_f(rom_color[i], rom_number[i], int'(rom_addr[i]));
  end

  int checks = 0, errors = 0;

  // model: a blit accepted at edge t0 is described purely by c = edges since t0
  int         n = 0, t0 = 0;
  bit         act = 1'b0, fresh = 1'b1;
  logic [1:0] m_col = '0;
  logic [2:0] m_num = '0;
  int         m_x = 0, m_y = 0;

  int wcnt [2], dcnt [2], done_c [2], f_addr [2], f_data [2], l_addr [2], a30 [2];

  task automatic chk(input int i, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", i, nm, got, exp, n);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      wcnt[i] = 0; dcnt[i] = 0; done_c[i] = -1; f_addr[i] = -1; f_data[i] = -1; l_addr[i] = -1; a30[i] = -1;
    end
  endtask

  task automatic compare();
    int c, k, col, row, xx, yy;
    logic [7:0] d;
    logic ew;
    c = n - t0;
    for (int i = 0; i < 2; i++) begin
      ew = 1'b0; d = '0; xx = 0; yy = 0;
      if (act && c >= 1 && c <= W * H) begin
        k = c - 1; col = k % W; row = k / W;
        xx = m_x + col; yy = m_y + row;
        d = rom_f(m_col, m_num, k);
        ew = (xx < FBW) && (yy < FBH) && !(i == 0 && d == 8'hFF);
      end
      chk(i, "busy", busy[i], act && c <= W * H);
      chk(i, "done", done[i], act && c == W * H + 1);
      chk(i, "fb_we", fb_we[i], ew);
      if (ew) begin
        chk(i, "fb_addr", fb_addr[i], yy * FBW + xx);
        chk(i, "fb_data", fb_data[i], d);
      end
      chk(i, "rom_color", rom_color[i], m_col);
      chk(i, "rom_number", rom_number[i], m_num);
      if (act && c < W * H) chk(i, "rom_addr", rom_addr[i], c);
      else if (fresh) chk(i, "rom_addr_idle", rom_addr[i], 0);
      if (fb_we[i] === 1'b1) begin
        if (wcnt[i] == 0) begin f_addr[i] = fb_addr[i]; f_data[i] = fb_data[i]; end
        wcnt[i]++;
        l_addr[i] = fb_addr[i];
        if (act && c == 31) a30[i] = fb_addr[i];
      end
      if (done[i] === 1'b1) begin dcnt[i]++; done_c[i] = c; end
    end
  endtask

  task automatic scramble();
    cmd_color  = 2'($urandom);
    cmd_number = 3'($urandom_range(0, 4));
    cmd_x      = 8'($urandom);
    cmd_y      = 7'($urandom);
  endtask

  task automatic tick(input logic s, input logic r);
    start = s; reset = r;
    if (!s) scramble();
    @(posedge clk);
    n++;
    if (r) begin
      act = 1'b0; fresh = 1'b1; m_col = '0; m_num = '0;
    end else if (act) begin
      if (n - t0 == W * H + 2) act = 1'b0;
    end else if (s) begin
      act = 1'b1; fresh = 1'b0; t0 = n;
      m_col = cmd_color; m_num = cmd_number; m_x = cmd_x; m_y = cmd_y;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic blit(input logic [1:0] c, input logic [2:0] nm, input logic [7:0] x, input logic [6:0] y);
    clr();
    cmd_color = c; cmd_number = nm; cmd_x = x; cmd_y = y;
    tick(1'b1, 1'b0);
    repeat (W * H + 3) tick(1'b0, 1'b0);
  endtask

  initial begin
    clr();
    repeat (3) tick(1'b0, 1'b1);

    blit(2'd0, 3'd0, 8'd0, 7'd0);
    chk(1, "red0_writes", wcnt[1], 900);
    chk(0, "red0_writes", wcnt[0], 897);
    for (int i = 0; i < 2; i++) begin
      chk(i, "red0_first_addr", f_addr[i], 0);
      chk(i, "red0_first_data", f_data[i], 32'h5A);
      chk(i, "red0_k30_addr", a30[i], 160);
      chk(i, "red0_last_addr", l_addr[i], 4669);
      chk(i, "red0_dones", dcnt[i], 1);
      chk(i, "red0_done_cycle", done_c[i], 901);
    end

    blit(2'd0, 3'd0, 8'd150, 7'd100);
    chk(1, "clip_writes", wcnt[1], 200);
    chk(0, "clip_writes", wcnt[0], 199);
    for (int i = 0; i < 2; i++) begin
      chk(i, "clip_first_addr", f_addr[i], 16150);
      chk(i, "clip_last_addr", l_addr[i], 19199);
      chk(i, "clip_done_cycle", done_c[i], 901);
    end

    blit(2'd1, 3'd4, 8'd10, 7'd10);
    chk(0, "blank_writes", wcnt[0], 0);
    chk(1, "blank_writes", wcnt[1], 900);
    chk(1, "blank_data", f_data[1], 32'hFF);
    chk(0, "blank_done_cycle", done_c[0], 901);
    chk(1, "blank_done_cycle", done_c[1], 901);

    // second start mid-blit is ignored
    clr();
    cmd_color = 2'd2; cmd_number = 3'd1; cmd_x = 8'd5; cmd_y = 7'd5;
    tick(1'b1, 1'b0);
    repeat (299) tick(1'b0, 1'b0);
    cmd_color = 2'd1; cmd_number = 3'd2;
    tick(1'b1, 1'b0);
    repeat (610) tick(1'b0, 1'b0);
    chk(0, "restart_dones", dcnt[0], 1);
    chk(1, "restart_dones", dcnt[1], 1);

    // reset at E400 aborts the blit with no done
    clr();
    cmd_color = 2'd3; cmd_number = 3'd3; cmd_x = 8'd20; cmd_y = 7'd40;
    tick(1'b1, 1'b0);
    repeat (399) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (600) tick(1'b0, 1'b0);
    chk(0, "reset_dones", dcnt[0], 0);
    chk(1, "reset_dones", dcnt[1], 0);
    blit(2'd3, 3'd2, 8'd140, 7'd3);
    chk(0, "post_reset_done", done_c[0], 901);
    chk(1, "post_reset_done", done_c[1], 901);

    // start held high: back-to-back blits, one IDLE cycle apart
    clr();
    repeat (1810) begin scramble(); tick(1'b1, 1'b0); end
    chk(0, "held_dones", dcnt[0], 2);
    chk(1, "held_dones", dcnt[1], 2);
    repeat (1000) tick(1'b0, 1'b0);

    repeat (4) begin
      clr();
      scramble();
      cmd_x = 8'($urandom_range(0, 175));
      tick(1'b1, 1'b0);
      repeat (W * H + 2) tick(($urandom_range(0, 15) == 0), 1'b0);
      chk(0, "rand_dones", dcnt[0], 1);
      chk(1, "rand_dones", dcnt[1], 1);
    end
    repeat (4) tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
